// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Purpose:
//   Streaming encoder that packs a 32-bit immediate into the immediate-field bit
//   positions of a RISC-V instruction word. It is the inverse of the core's
//   immediate sign-extension path. Decoding the produced instruction with the
//   same imm_sel returns imm whenever neither error flag is raised.
//   Encoding is combinational on the input side. Each accepted beat is written
//   into a 2-entry output FIFO together with its per-beat error flags.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   in_valid    in   input beat valid
//   in_ready    out  block can accept a beat (count < 2, low while in reset)
//   imm_sel     in   000 I, 001 I_U (shamt), 010 S, 011 B, 100 J, 101 U; 11x illegal
//   imm         in   immediate value as the decoder would produce it
//   instr_base  in   instruction carrying the non-immediate fields
//   out_valid   out  output beat valid
//   out_ready   in   consumer accepts the output beat
//   instr       out  encoded instruction
//   range_err   out  imm not representable in the selected format
//   sel_err     out  illegal imm_sel
//   err_count   out  saturating count of accepted beats carrying an error
//
// Configuration:
//   IMM_ENC_ERRCNT_EN  when defined, err_count counts accepted erroneous beats
//                      and saturates at all-ones. When undefined, err_count
//                      is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_sel,
  input  logic [31:0]          imm,
  input  logic [31:0]          instr_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 range_err,
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] SEL_I  = 3'b000;
  localparam logic [2:0] SEL_IU = 3'b001;
  localparam logic [2:0] SEL_S  = 3'b010;
  localparam logic [2:0] SEL_B  = 3'b011;
  localparam logic [2:0] SEL_J  = 3'b100;
  localparam logic [2:0] SEL_U  = 3'b101;

  logic [31:0] encInstr;
  logic        encRange;
  logic        encSel;

  logic [31:0] clearedBase;
  logic [31:0] packedInstr;

  logic [33:0] memQ [2];
  logic        wrPtrQ, wrPtrD;
  logic        rdPtrQ, rdPtrD;
  logic [1:0]  countQ, countD;

  logic        push;
  logic        pop;

  // Format-specific encoding. clearedBase is the base with the immediate field
  // zeroed and is the fallback output on a range error. packedInstr is the
  // fully encoded word. A field is "representable" when every bit above the
  // format's sign bit equals that sign bit. This is why the checks below test
  // for all-ones or all-zeros.
  always_comb begin
    clearedBase = instr_base;
    packedInstr = instr_base;
    encRange    = 1'b0;
    encSel      = 1'b0;
    unique case (imm_sel)
      SEL_I: begin
        clearedBase = instr_base & 32'h000F_FFFF;
        packedInstr = {imm[11:0], instr_base[19:0]};
        encRange    = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SEL_IU: begin
        // funct7 in [31:25] distinguishes SRLI/SRAI, so only the shamt is replaced
        clearedBase = instr_base & 32'hFE0F_FFFF;
        packedInstr = {instr_base[31:25], imm[4:0], instr_base[19:0]};
        encRange    = |imm[31:5];
      end
      SEL_S: begin
        clearedBase = instr_base & 32'h01FF_F07F;
        packedInstr = {imm[11:5], instr_base[24:12], imm[4:0], instr_base[6:0]};
        encRange    = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SEL_B: begin
        clearedBase = instr_base & 32'h01FF_F07F;
        packedInstr = {imm[12], imm[10:5], instr_base[24:12],
                       imm[4:1], imm[11], instr_base[6:0]};
        encRange    = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      SEL_J: begin
        clearedBase = instr_base & 32'h0000_0FFF;
        packedInstr = {imm[20], imm[10:1], imm[11], imm[19:12], instr_base[11:0]};
        encRange    = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      SEL_U: begin
        clearedBase = instr_base & 32'h0000_0FFF;
        packedInstr = {imm[31:12], instr_base[11:0]};
        encRange    = |imm[11:0];
      end
      default: begin
        // Illegal selector: pass the base through untouched, never flag range
        encSel = 1'b1;
      end
    endcase
    encInstr = encRange ? clearedBase : packedInstr;
  end

  // Handshake. in_ready depends only on stored occupancy and the reset input,
  // so a consumer's out_ready never reaches the producer combinationally.
  assign in_ready  = !reset && (countQ != 2'd2);
  assign out_valid = (countQ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Output fields are forced to zero while empty. This keeps the idle and
  // post-reset output deterministic. The head entry is stable until it is popped.
  always_comb begin
    {instr, range_err, sel_err} = out_valid ? memQ[rdPtrQ] : 34'd0;
  end

  // Pointer and occupancy next-state. A simultaneous push and pop leaves the
  // count unchanged while both pointers advance, which preserves order.
  always_comb begin
    wrPtrD = push ? ~wrPtrQ : wrPtrQ;
    rdPtrD = pop  ? ~rdPtrQ : rdPtrQ;
    countD = countQ;
    unique case ({push, pop})
      2'b10:   countD = countQ + 2'd1;
      2'b01:   countD = countQ - 2'd1;
      default: countD = countQ;
    endcase
  end

  // FIFO state. Reset discards queued beats and clears the storage so that
  // nothing queued before reset can reappear afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrQ  <= 1'b0;
      rdPtrQ  <= 1'b0;
      countQ  <= 2'd0;
      memQ[0] <= 34'd0;
      memQ[1] <= 34'd0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
      if (push) begin
        memQ[wrPtrQ] <= {encInstr, encRange, encSel};
      end
    end
  end

`ifdef IMM_ENC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] errCntQ, errCntD;

  // Count accepted beats that carry either error flag. The counter sticks
  // at all-ones rather than wrapping.
  always_comb begin
    errCntD = errCntQ;
    if (push && (encRange || encSel) && !(&errCntQ)) begin
      errCntD = errCntQ + 1'b1;
    end
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      errCntQ <= '0;
    end else begin
      errCntQ <= errCntD;
    end
  end

  assign err_count = errCntQ;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//
// Self-checking bench for imm_encoder. Every accepted beat pushes its expected
// {instr, range_err, sel_err} onto a scoreboard queue. Each output handshake
// pops one entry and compares it. The scenario tasks also check handshake
// timing, holding and reset behaviour directly.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

  localparam int ERR_CNT_W = 8;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           imm_sel;
  logic [31:0]          imm;
  logic [31:0]          instr_base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          instr;
  logic                 range_err;
  logic                 sel_err;
  logic [ERR_CNT_W-1:0] err_count;

  logic [31:0] expInstr;
  logic        expRange;
  logic        expSel;

  logic [33:0] scoreQ [$];
  int          checks;
  int          errors;
  int          popCnt;

  imm_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_sel    (imm_sel),
    .imm        (imm),
    .instr_base (instr_base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .range_err  (range_err),
    .sel_err    (sel_err),
    .err_count  (err_count)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor. It samples at the negedge, where inputs and outputs are
  // stable ahead of the next rising edge. It pops before pushing because the
  // head entry is always older than a beat being accepted in the same cycle.
  always @(negedge clk) begin
    logic [33:0] head;
    if (!reset && out_valid && out_ready) begin
      checks++;
      popCnt++;
      if (scoreQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat: got instr=%h, want no beat", instr);
      end else begin
        head = scoreQ.pop_front();
        if ({instr, range_err, sel_err} !== head) begin
          errors++;
          $display("[TB] FAIL beat_data: got instr=%h range=%b sel=%b, want instr=%h range=%b sel=%b",
                   instr, range_err, sel_err, head[33:2], head[1], head[0]);
        end
      end
    end
    if (!reset && in_valid && in_ready) begin
      scoreQ.push_back({expInstr, expRange, expSel});
    end
  end

  // Align to just after a rising edge
  task automatic alignIn();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted. Expects to be called just after
  // a rising edge and returns just after the accepting edge, so consecutive
  // calls are back-to-back. waits counts the cycles the beat was refused.
  task automatic driveBeat(input logic [2:0] s, input logic [31:0] im, input logic [31:0] b,
                           input logic [31:0] eI, input logic eR, input logic eS,
                           output int waits);
    bit accepted;
    accepted   = 1'b0;
    waits      = 0;
    in_valid   = 1'b1;
    imm_sel    = s;
    imm        = im;
    instr_base = b;
    expInstr   = eI;
    expRange   = eR;
    expSel     = eS;
    while (!accepted && waits < 50) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      if (!accepted) waits++;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept, want accept within 50 cycles");
    end
  endtask

  task automatic idleIn();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    imm_sel   = 3'd0;
    imm       = 32'd0;
    instr_base = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, instr, range_err, sel_err, err_count, in_ready} !==
        {1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state: got v=%b i=%h r=%b s=%b c=%0d rdy=%b want v=0 i=0 r=0 s=0 c=0 rdy=1",
               out_valid, instr, range_err, sel_err, err_count, in_ready);
    end
  endtask

  task automatic test_basic_formats();
    logic [2:0]  selT  [6] = '{3'b000, 3'b010, 3'b101, 3'b011, 3'b001, 3'b000};
    logic [31:0] immT  [6] = '{32'hFFFF_FFFF, 32'd8, 32'h1234_5000, 32'hFFFF_FFFC, 32'd7, 32'hFFFF_F800};
    logic [31:0] baseT [6] = '{32'h0000_0013, 32'h0000_2023, 32'h0000_0037, 32'h0000_0063,
                               32'h4000_5013, 32'h0000_0013};
    logic [31:0] expT  [6] = '{32'hFFF0_0013, 32'h0000_2423, 32'h1234_5037, 32'hFE00_0EE3,
                               32'h4070_5013, 32'h8000_0013};
    int waits;
    out_ready = 1'b1;
    alignIn();
    for (int i = 0; i < 6; i++) begin
      driveBeat(selT[i], immT[i], baseT[i], expT[i], 1'b0, 1'b0, waits);
      idleIn();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || instr !== expT[i] || range_err !== 1'b0 || sel_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_latency_%0d: got v=%b i=%h r=%b s=%b want v=1 i=%h r=0 s=0",
                 i, out_valid, instr, range_err, sel_err, expT[i]);
      end
      alignIn();
    end
  endtask

  task automatic test_errors();
    int waits;
    logic [ERR_CNT_W-1:0] expCnt;
    out_ready = 1'b1;
    alignIn();
    driveBeat(3'b000, 32'd2048, 32'hABC0_0013, 32'h0000_0013, 1'b1, 1'b0, waits);
    driveBeat(3'b100, 32'd3, 32'hFFFF_F0EF, 32'h0000_00EF, 1'b1, 1'b0, waits);
    driveBeat(3'b110, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, waits);
    idleIn();
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef IMM_ENC_ERRCNT_EN
    expCnt = 8'd3;
`else
    expCnt = 8'd0;
`endif
    checks++;
    if (err_count !== expCnt) begin
      errors++;
      $display("[TB] FAIL err_count_after_errors: got %0d want %0d", err_count, expCnt);
    end
    alignIn();
    // Out of range for B: bit 12 set with zeros above it
    driveBeat(3'b011, 32'h0000_1000, 32'hFFFF_FFE3, 32'h01FF_F063, 1'b1, 1'b0, waits);
    // Out of range for U: low 12 bits nonzero
    driveBeat(3'b101, 32'h0000_0001, 32'hFFFF_FFB7, 32'h0000_0FB7, 1'b1, 1'b0, waits);
    idleIn();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int waits;
    int popStart;
    popStart  = popCnt;
    out_ready = 1'b0;
    alignIn();
    driveBeat(3'b000, 32'd10, 32'h0000_0013, 32'h00A0_0013, 1'b0, 1'b0, waits);
    driveBeat(3'b000, 32'd11, 32'h0000_0013, 32'h00B0_0013, 1'b0, 1'b0, waits);
    in_valid   = 1'b1;
    imm_sel    = 3'b000;
    imm        = 32'd12;
    instr_base = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr !== 32'h00A0_0013) begin
        errors++;
        $display("[TB] FAIL full_hold_%0d: got rdy=%b v=%b i=%h want rdy=0 v=1 i=00a00013",
                 i, in_ready, out_valid, instr);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    driveBeat(3'b000, 32'd12, 32'h0000_0013, 32'h00C0_0013, 1'b0, 1'b0, waits);
    idleIn();
    checks++;
    if (waits !== 1) begin
      errors++;
      $display("[TB] FAIL third_after_first_pop: got waits=%0d want 1", waits);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || instr !== 32'h00C0_0013) begin
      errors++;
      $display("[TB] FAIL third_beat_out: got v=%b i=%h want v=1 i=00c00013", out_valid, instr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (popCnt - popStart !== 3 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_drain: got pops=%0d v=%b want pops=3 v=0",
               popCnt - popStart, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int waits;
    int popStart;
    popStart  = popCnt;
    out_ready = 1'b1;
    alignIn();
    for (int i = 1; i <= 3; i++) begin
      driveBeat(3'b000, i, 32'h0000_0013, (32'(i) << 20) | 32'h13, 1'b0, 1'b0, waits);
      checks++;
      if (waits !== 0) begin
        errors++;
        $display("[TB] FAIL push_pop_ready_%0d: got waits=%0d want 0", i, waits);
      end
    end
    idleIn();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || instr !== 32'h0030_0013) begin
      errors++;
      $display("[TB] FAIL push_pop_last: got v=%b i=%h want v=1 i=00300013", out_valid, instr);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || popCnt - popStart !== 3) begin
      errors++;
      $display("[TB] FAIL push_pop_count: got v=%b pops=%0d want v=0 pops=3",
               out_valid, popCnt - popStart);
    end
  endtask

  task automatic test_reset_midop();
    int waits;
    out_ready = 1'b0;
    alignIn();
    driveBeat(3'b000, 32'd2048, 32'h0000_0013, 32'h0000_0013, 1'b1, 1'b0, waits);
    driveBeat(3'b101, 32'h0000_1000, 32'h0000_0037, 32'h0000_1037, 1'b0, 1'b0, waits);
    idleIn();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    alignIn();
    reset = 1'b1;
    scoreQ.delete();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_reset_ready: got %b want 0", in_ready);
    end
    alignIn();
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b1 || instr !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midop_after_reset: got v=%b c=%0d rdy=%b i=%h want v=0 c=0 rdy=1 i=0",
               out_valid, err_count, in_ready, instr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midop_no_beat_%0d: got v=%b want 0", i, out_valid);
      end
    end
  endtask

  // Scenario sequence, final drain check and summary
  initial begin
    checks   = 0;
    errors   = 0;
    popCnt   = 0;
    expInstr = 32'd0;
    expRange = 1'b0;
    expSel   = 1'b0;
    test_reset();
    test_basic_formats();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    repeat (3) @(posedge clk);
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", scoreQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
